dmem_sched: RTL and testbench

//  Scheduler for the shared single-port data memory of the dual-issue core.

---
 rtl/dmem_sched_pkg.sv | 32 +++
 rtl/dmem_sched_if.sv | 44 ++++
 rtl/dmem_sched_slot.sv | 45 ++++
 rtl/dmem_sched.sv | 120 ++++++++++++
 tb/tb_dmem_sched.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_sched_pkg.sv
// Shared types for the data-memory scheduler: lane op codes, FSM states and
// the per-slot control fields.
package dmem_sched_pkg;

    localparam int RD_W = 5;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_LW   = 2'b01,
        OP_SW   = 2'b10,
        OP_RSV  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE0,
        S_ISSUE1,
        S_WAIT0,
        S_WAIT1
    } state_e;

    typedef struct packed {
        op_e             op;
        logic [RD_W-1:0] rd;
    } slot_t;

    // Reserved encoding behaves exactly like an empty lane.
    function automatic logic op_active(input op_e op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/dmem_sched_if.sv
// Issue-bundle, memory-port and writeback signals of the scheduler.
// The slave modport is the scheduler's view; master is the core + RAM side.
interface dmem_sched_if #(
    parameter int AW = 12,
    parameter int DW = 32
);
    logic          bundle_valid;
    logic          bundle_ready;
    logic [1:0]    l0_op;
    logic [1:0]    l1_op;
    logic [31:0]   l0_addr;
    logic [31:0]   l1_addr;
    logic [DW-1:0] l0_wdata;
    logic [DW-1:0] l1_wdata;
    logic [4:0]    l0_rd;
    logic [4:0]    l1_rd;
    logic          flush;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          wb_valid;
    logic [4:0]    wb_rd;
    logic [DW-1:0] wb_data;
    logic          busy;

    modport slave (
        input  bundle_valid, l0_op, l1_op, l0_addr, l1_addr,
               l0_wdata, l1_wdata, l0_rd, l1_rd, flush, mem_rdata,
        output bundle_ready, mem_en, mem_we, mem_addr, mem_wdata,
               wb_valid, wb_rd, wb_data, busy
    );

    modport master (
        output bundle_valid, l0_op, l1_op, l0_addr, l1_addr,
               l0_wdata, l1_wdata, l0_rd, l1_rd, flush, mem_rdata,
        input  bundle_ready, mem_en, mem_we, mem_addr, mem_wdata,
               wb_valid, wb_rd, wb_data, busy
    );

endinterface

// File: rtl/dmem_sched_slot.sv
// One lane slot: holds op, truncated word address, store data and load rd.
// Clear wins over load so a flush coinciding with accept drops the lane.
module dmem_slot
    import dmem_sched_pkg::*;
#(
    parameter int AW = 12,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic          i_clear,
    input  slot_t         i_slot,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    output slot_t         o_slot,
    output logic [AW-1:0] o_addr,
    output logic [DW-1:0] o_wdata
);
    slot_t         r_slot;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_slot  <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (i_clear) begin
            r_slot  <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (i_load) begin
            r_slot  <= i_slot;
            r_addr  <= i_addr;
            r_wdata <= i_wdata;
        end
    end

    assign o_slot  = r_slot;
    assign o_addr  = r_addr;
    assign o_wdata = r_wdata;

endmodule

// File: rtl/dmem_sched.sv
// Serializes a two-lane lw/sw bundle onto the single-port dmem, lane0 first,
// returning load data on one writeback port and stalling decode while busy.
module dmem_sched
    import dmem_sched_pkg::*;
#(
    parameter int AW      = 12,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input logic         clk,
    input logic         rst,
    dmem_sched_if.slave bus
);
    localparam int CW = $clog2(MEM_LAT + 1);

    state_e          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_wb_valid;
    logic [RD_W-1:0] r_wb_rd;
    logic [DW-1:0]   r_wb_data;

    slot_t           w_l0, w_l1, w_s0, w_s1, w_cur;
    logic [AW-1:0]   w_s0_addr, w_s1_addr;
    logic [DW-1:0]   w_s0_wdata, w_s1_wdata;
    logic            w_idle, w_accept, w_on_s1, w_issue, w_s1_live, w_s1_clear;

    assign w_idle     = (r_state == S_IDLE);
    assign w_accept   = w_idle && bus.bundle_valid;
    assign w_on_s1    = (r_state == S_ISSUE1) || (r_state == S_WAIT1);
    assign w_issue    = (r_state == S_ISSUE0) || (r_state == S_ISSUE1);
    assign w_l0       = '{op: op_e'(bus.l0_op), rd: bus.l0_rd};
    assign w_l1       = '{op: op_e'(bus.l1_op), rd: bus.l1_rd};
    assign w_cur      = w_on_s1 ? w_s1 : w_s0;
    // Flush only reaches slot1 while it has not been strobed yet.
    assign w_s1_live  = op_active(w_s1.op) && !bus.flush;
    assign w_s1_clear = bus.flush && !w_on_s1;

    dmem_slot #(.AW(AW), .DW(DW)) u_slot0 (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_accept),
        .i_clear (1'b0),
        .i_slot  (w_l0),
        .i_addr  (bus.l0_addr[AW-1:0]),
        .i_wdata (bus.l0_wdata),
        .o_slot  (w_s0),
        .o_addr  (w_s0_addr),
        .o_wdata (w_s0_wdata)
    );

    dmem_slot #(.AW(AW), .DW(DW)) u_slot1 (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_accept),
        .i_clear (w_s1_clear),
        .i_slot  (w_l1),
        .i_addr  (bus.l1_addr[AW-1:0]),
        .i_wdata (bus.l1_wdata),
        .o_slot  (w_s1),
        .o_addr  (w_s1_addr),
        .o_wdata (w_s1_wdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_wb_valid <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
        end else begin
            r_wb_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (op_active(w_l0.op))                   r_state <= S_ISSUE0;
                        else if (op_active(w_l1.op) && !bus.flush) r_state <= S_ISSUE1;
                    end
                end
                S_ISSUE0, S_ISSUE1: begin
                    if (w_cur.op == OP_LW) begin
                        r_state <= (r_state == S_ISSUE0) ? S_WAIT0 : S_WAIT1;
                        r_cnt   <= CW'(MEM_LAT);
                    end else if (r_state == S_ISSUE0 && w_s1_live) begin
                        r_state <= S_ISSUE1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_WAIT0, S_WAIT1: begin
                    // Count runs L..1 while data is in flight; the cycle at 0 is the wb pulse.
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CW'(1);
                        if (r_cnt == CW'(1)) begin
                            r_wb_data  <= bus.mem_rdata;
                            r_wb_rd    <= w_cur.rd;
                            r_wb_valid <= (w_cur.rd != '0);
                        end
                    end else if (r_state == S_WAIT0 && w_s1_live) begin
                        r_state <= S_ISSUE1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.bundle_ready = w_idle;
    assign bus.busy         = !w_idle;
    assign bus.mem_en       = w_issue;
    assign bus.mem_we       = w_issue && (w_cur.op == OP_SW);
    assign bus.mem_addr     = w_on_s1 ? w_s1_addr : w_s0_addr;
    assign bus.mem_wdata    = w_on_s1 ? w_s1_wdata : w_s0_wdata;
    assign bus.wb_valid     = r_wb_valid;
    assign bus.wb_rd        = r_wb_rd;
    assign bus.wb_data      = r_wb_data;

endmodule

// File: tb/tb_dmem_sched.sv
// Directed bench for dmem_sched: two instances (read latency 1 and 3) share
// stimulus, each backed by its own RAM model.
module tb_dmem_sched;
    import dmem_sched_pkg::*;

    localparam int AW = 12;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          t_valid, t_flush, sel, ram_init;
    logic [1:0]    t_l0_op, t_l1_op;
    logic [31:0]   t_l0_addr, t_l1_addr, t_l0_wdata, t_l1_wdata;
    logic [4:0]    t_l0_rd, t_l1_rd;

    dmem_sched_if #(.AW(AW), .DW(DW)) bus1 ();
    dmem_sched_if #(.AW(AW), .DW(DW)) bus3 ();

    dmem_sched #(.AW(AW), .DW(DW), .MEM_LAT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
    dmem_sched #(.AW(AW), .DW(DW), .MEM_LAT(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

    assign bus1.bundle_valid = t_valid;   assign bus3.bundle_valid = t_valid;
    assign bus1.flush        = t_flush;   assign bus3.flush        = t_flush;
    assign bus1.l0_op        = t_l0_op;   assign bus3.l0_op        = t_l0_op;
    assign bus1.l1_op        = t_l1_op;   assign bus3.l1_op        = t_l1_op;
    assign bus1.l0_addr      = t_l0_addr; assign bus3.l0_addr      = t_l0_addr;
    assign bus1.l1_addr      = t_l1_addr; assign bus3.l1_addr      = t_l1_addr;
    assign bus1.l0_wdata     = t_l0_wdata; assign bus3.l0_wdata    = t_l0_wdata;
    assign bus1.l1_wdata     = t_l1_wdata; assign bus3.l1_wdata    = t_l1_wdata;
    assign bus1.l0_rd        = t_l0_rd;   assign bus3.l0_rd        = t_l0_rd;
    assign bus1.l1_rd        = t_l1_rd;   assign bus3.l1_rd        = t_l1_rd;

    // RAM models: reads return a poison word unless a read strobe was seen
    // exactly L cycles earlier.
    logic [31:0] ram1 [0:4095];
    logic [31:0] ram3 [0:4095];
    logic [31:0] rd1_q;
    logic [31:0] rd3_q [0:2];

    always @(posedge clk) begin
        if (ram_init) begin
            for (int a = 0; a < 4096; a++) begin
                ram1[a] <= 32'hD000_0000 | 32'(a);
                ram3[a] <= 32'hD000_0000 | 32'(a);
            end
        end else begin
            if (bus1.mem_en && bus1.mem_we) ram1[bus1.mem_addr] <= bus1.mem_wdata;
            if (bus3.mem_en && bus3.mem_we) ram3[bus3.mem_addr] <= bus3.mem_wdata;
        end
        rd1_q    <= (bus1.mem_en && !bus1.mem_we) ? ram1[bus1.mem_addr] : 32'hDEAD_DEAD;
        rd3_q[0] <= (bus3.mem_en && !bus3.mem_we) ? ram3[bus3.mem_addr] : 32'hDEAD_DEAD;
        rd3_q[1] <= rd3_q[0];
        rd3_q[2] <= rd3_q[1];
    end

    assign bus1.mem_rdata = rd1_q;
    assign bus3.mem_rdata = rd3_q[2];

    logic        s_en, s_we, s_wb, s_ready, s_busy;
    logic [11:0] s_addr;
    logic [31:0] s_wdata, s_wb_data;
    logic [4:0]  s_wb_rd;

    assign s_en      = sel ? bus3.mem_en       : bus1.mem_en;
    assign s_we      = sel ? bus3.mem_we       : bus1.mem_we;
    assign s_wb      = sel ? bus3.wb_valid     : bus1.wb_valid;
    assign s_ready   = sel ? bus3.bundle_ready : bus1.bundle_ready;
    assign s_busy    = sel ? bus3.busy         : bus1.busy;
    assign s_addr    = sel ? bus3.mem_addr     : bus1.mem_addr;
    assign s_wdata   = sel ? bus3.mem_wdata    : bus1.mem_wdata;
    assign s_wb_data = sel ? bus3.wb_data      : bus1.wb_data;
    assign s_wb_rd   = sel ? bus3.wb_rd        : bus1.wb_rd;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        t_valid = 1'b0; t_flush = 1'b0;
        t_l0_op = OP_NONE; t_l1_op = OP_NONE;
        t_l0_addr = '0; t_l1_addr = '0; t_l0_wdata = '0; t_l1_wdata = '0;
        t_l0_rd = '0; t_l1_rd = '0;
    endtask

    task automatic wait_idle();
        logic both = 1'b0;
        for (int c = 0; c < 30 && !both; c++) begin
            both = bus1.bundle_ready && bus3.bundle_ready;
            if (!both) step();
        end
        check("both_idle", 32'(both), 32'd1);
    endtask

    typedef struct {
        bit          sel;
        logic [1:0]  l0_op;
        logic [31:0] l0_addr;
        logic [31:0] l0_wdata;
        logic [4:0]  l0_rd;
        logic [1:0]  l1_op;
        logic [31:0] l1_addr;
        logic [31:0] l1_wdata;
        logic [4:0]  l1_rd;
        bit          flush;
        int          exp_en;
        int          exp_wb;
        logic [4:0]  exp_rd;
        logic [31:0] exp_data;
        int          exp_ready;
        logic [11:0] exp_addr0;
        bit          exp_we0;
    } vec_t;

    task automatic run_vec(input int idx, input vec_t v);
        int n_en = 0, n_wb = 0, rdy = -1;
        logic [4:0]  wrd = '0;
        logic [31:0] wdat = '0;
        logic [11:0] a0 = '0;
        logic        we0 = 1'b0;
        sel = v.sel;
        t_l0_op = v.l0_op; t_l0_addr = v.l0_addr; t_l0_wdata = v.l0_wdata; t_l0_rd = v.l0_rd;
        t_l1_op = v.l1_op; t_l1_addr = v.l1_addr; t_l1_wdata = v.l1_wdata; t_l1_rd = v.l1_rd;
        t_flush = v.flush; t_valid = 1'b1;
        check($sformatf("v%0d ready_at_accept", idx), 32'(s_ready), 32'd1);
        step();
        clear_inputs();
        for (int c = 1; c <= 24 && rdy < 0; c++) begin
            if (s_en) begin
                if (n_en == 0) begin a0 = s_addr; we0 = s_we; end
                n_en++;
            end
            if (s_wb) begin n_wb++; wrd = s_wb_rd; wdat = s_wb_data; end
            if (s_ready) rdy = c;
            else step();
        end
        check($sformatf("v%0d mem_en_count", idx), 32'(n_en), 32'(v.exp_en));
        check($sformatf("v%0d wb_count", idx), 32'(n_wb), 32'(v.exp_wb));
        check($sformatf("v%0d ready_cycle", idx), 32'(rdy), 32'(v.exp_ready));
        if (v.exp_en > 0) begin
            check($sformatf("v%0d first_addr", idx), 32'(a0), 32'(v.exp_addr0));
            check($sformatf("v%0d first_we", idx), 32'(we0), 32'(v.exp_we0));
        end
        if (v.exp_wb > 0) begin
            check($sformatf("v%0d wb_rd", idx), 32'(wrd), 32'(v.exp_rd));
            check($sformatf("v%0d wb_data", idx), wdat, v.exp_data);
        end
        wait_idle();
    endtask

    vec_t vecs [15];

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int n_en, n_wb, rdy;
        vecs[0]  = '{0, OP_LW,   32'h20,       32'h0,    5'd4,  OP_NONE, 32'h0,  32'h0,    5'd0,  0, 1, 1, 5'd4,  32'hD000_0020, 4,  12'h020, 1'b0};
        vecs[1]  = '{1, OP_LW,   32'hFFFF_F021, 32'h0,   5'd5,  OP_NONE, 32'h0,  32'h0,    5'd0,  0, 1, 1, 5'd5,  32'hD000_0021, 6,  12'h021, 1'b0};
        vecs[2]  = '{0, OP_SW,   32'h30,       32'h1234, 5'd0,  OP_NONE, 32'h0,  32'h0,    5'd0,  0, 1, 0, 5'd0,  32'h0,         2,  12'h030, 1'b1};
        vecs[3]  = '{0, OP_NONE, 32'h0,        32'h0,    5'd0,  OP_LW,   32'h30, 32'h0,    5'd7,  0, 1, 1, 5'd7,  32'h1234,      4,  12'h030, 1'b0};
        vecs[4]  = '{1, OP_LW,   32'h40,       32'h0,    5'd0,  OP_LW,   32'h41, 32'h0,    5'd3,  0, 2, 1, 5'd3,  32'hD000_0041, 11, 12'h040, 1'b0};
        vecs[5]  = '{0, OP_SW,   32'h5,        32'h77,   5'd0,  OP_LW,   32'h5,  32'h0,    5'd9,  0, 2, 1, 5'd9,  32'h77,        5,  12'h005, 1'b1};
        vecs[6]  = '{0, OP_RSV,  32'h8,        32'h0,    5'd6,  OP_NONE, 32'h0,  32'h0,    5'd0,  0, 0, 0, 5'd0,  32'h0,         1,  12'h000, 1'b0};
        vecs[7]  = '{0, OP_NONE, 32'h9,        32'h0,    5'd6,  OP_NONE, 32'h9,  32'h0,    5'd6,  0, 0, 0, 5'd0,  32'h0,         1,  12'h000, 1'b0};
        vecs[8]  = '{0, OP_RSV,  32'h0,        32'h0,    5'd0,  OP_SW,   32'h50, 32'hBEEF, 5'd0,  0, 1, 0, 5'd0,  32'h0,         2,  12'h050, 1'b1};
        vecs[9]  = '{0, OP_LW,   32'h50,       32'h0,    5'd2,  OP_LW,   32'h51, 32'h0,    5'd6,  1, 1, 1, 5'd2,  32'hBEEF,      4,  12'h050, 1'b0};
        vecs[10] = '{0, OP_NONE, 32'h0,        32'h0,    5'd0,  OP_LW,   32'h60, 32'h0,    5'd1,  1, 0, 0, 5'd0,  32'h0,         1,  12'h000, 1'b0};
        vecs[11] = '{0, OP_SW,   32'h60,       32'h11,   5'd0,  OP_SW,   32'h61, 32'h22,   5'd0,  0, 2, 0, 5'd0,  32'h0,         3,  12'h060, 1'b1};
        vecs[12] = '{1, OP_LW,   32'h61,       32'h0,    5'd31, OP_LW,   32'h60, 32'h0,    5'd30, 0, 2, 2, 5'd30, 32'h11,        11, 12'h061, 1'b0};
        vecs[13] = '{0, OP_LW,   32'h60,       32'h0,    5'd12, OP_SW,   32'h62, 32'h33,   5'd0,  0, 2, 1, 5'd12, 32'h11,        5,  12'h060, 1'b0};
        vecs[14] = '{0, OP_SW,   32'h10,       32'hCAFE, 5'd0,  OP_NONE, 32'h0,  32'h0,    5'd0,  0, 1, 0, 5'd0,  32'h0,         2,  12'h010, 1'b1};

        clear_inputs();
        sel = 1'b0;
        ram_init = 1'b1;
        step();
        step();
        ram_init = 1'b0;
        check("reset ready", 32'(s_ready), 32'd1);
        check("reset busy", 32'(s_busy), 32'd0);
        check("reset mem_en", 32'(s_en), 32'd0);
        check("reset wb_valid", 32'(s_wb), 32'd0);
        rst = 1'b1;
        step();

        for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);

        // Exact single-lw timing at latency 1: strobe c1, wb c3, ready c4.
        sel = 1'b0;
        t_l0_op = OP_LW; t_l0_addr = 32'h10; t_l0_rd = 5'd8; t_valid = 1'b1;
        check("t2 c0 ready", 32'(s_ready), 32'd1);
        check("t2 c0 busy", 32'(s_busy), 32'd0);
        step();
        clear_inputs();
        check("t2 c1 mem_en", 32'(s_en), 32'd1);
        check("t2 c1 mem_addr", 32'(s_addr), 32'h010);
        check("t2 c1 mem_we", 32'(s_we), 32'd0);
        check("t2 c1 busy", 32'(s_busy), 32'd1);
        step();
        check("t2 c2 mem_en", 32'(s_en), 32'd0);
        check("t2 c2 wb_valid", 32'(s_wb), 32'd0);
        step();
        check("t2 c3 wb_valid", 32'(s_wb), 32'd1);
        check("t2 c3 wb_rd", 32'(s_wb_rd), 32'd8);
        check("t2 c3 wb_data", s_wb_data, 32'hCAFE);
        check("t2 c3 ready", 32'(s_ready), 32'd0);
        step();
        check("t2 c4 ready", 32'(s_ready), 32'd1);
        check("t2 c4 wb_valid", 32'(s_wb), 32'd0);
        wait_idle();

        // Flush during WAIT0 at latency 3: lw completes, lane1 sw is dropped.
        sel = 1'b1;
        t_l0_op = OP_LW; t_l0_addr = 32'h70; t_l0_rd = 5'd10;
        t_l1_op = OP_SW; t_l1_addr = 32'h71; t_l1_wdata = 32'h99; t_valid = 1'b1;
        step();
        clear_inputs();
        check("t5 c1 mem_en", 32'(s_en), 32'd1);
        n_en = 0; n_wb = 0; rdy = -1;
        step();
        for (int c = 2; c <= 20 && rdy < 0; c++) begin
            t_flush = (c == 2);
            if (s_en) n_en++;
            if (s_wb) begin
                n_wb++;
                check("t5 wb_rd", 32'(s_wb_rd), 32'd10);
                check("t5 wb_data", s_wb_data, 32'hD000_0070);
            end
            if (s_ready) rdy = c;
            else step();
        end
        t_flush = 1'b0;
        check("t5 extra mem_en", 32'(n_en), 32'd0);
        check("t5 wb_count", 32'(n_wb), 32'd1);
        check("t5 ready_cycle", 32'(rdy), 32'd6);
        wait_idle();
        check("t5 ram3 untouched", ram3[12'h071], 32'hD000_0071);
        check("t5 ram1 untouched", ram1[12'h071], 32'hD000_0071);

        // Asynchronous reset while WAIT0 is in flight.
        sel = 1'b1;
        t_l0_op = OP_LW; t_l0_addr = 32'h80; t_l0_wdata = 32'hA5A5; t_l0_rd = 5'd11; t_valid = 1'b1;
        step();
        clear_inputs();
        step();
        check("t1 pre addr", 32'(s_addr), 32'h080);
        rst = 1'b0;
        #1;
        check("t1 mem_en", 32'(s_en), 32'd0);
        check("t1 mem_we", 32'(s_we), 32'd0);
        check("t1 mem_addr", 32'(s_addr), 32'd0);
        check("t1 mem_wdata", s_wdata, 32'd0);
        check("t1 wb_valid", 32'(s_wb), 32'd0);
        check("t1 wb_rd", 32'(s_wb_rd), 32'd0);
        check("t1 wb_data", s_wb_data, 32'd0);
        check("t1 ready", 32'(s_ready), 32'd1);
        check("t1 busy", 32'(s_busy), 32'd0);
        step();
        rst = 1'b1;
        n_en = 0; n_wb = 0; rdy = 1;
        for (int c = 0; c < 6; c++) begin
            step();
            if (s_en) n_en++;
            if (s_wb) n_wb++;
            if (!s_ready) rdy = 0;
        end
        check("t1 no access after reset", 32'(n_en), 32'd0);
        check("t1 pending wb lost", 32'(n_wb), 32'd0);
        check("t1 stays ready", 32'(rdy), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
